// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the ID/EX pipeline register and the iterative M-extension unit.
// The master side drives the operation; the slave side (the unit) returns stall/busy/done/result.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            flush_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, flush_i, funct3_i, a_i, b_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, flush_i, funct3_i, a_i, b_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide on magnitudes,
// with sign fix-up applied on the final step and the corner cases resolved directly from IDLE.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  ex_muldiv_unit_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ONES    = '1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d, result_q, result_d;
  logic [2:0]      f3_q, f3_d;
  logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d;

  // One datapath step for each algorithm; {hi, lo} is the product / {remainder, quotient} pair.
  logic [XLEN:0]     mul_sum, div_tmp;
  logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo, div_sub, quo_fix, rem_fix, final_res;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic              div_ge, signed_a, signed_b, is_div_in;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi   = mul_sum[XLEN:1];
    mul_lo   = {mul_sum[0], lo_q[XLEN-1:1]};
    div_tmp  = {hi_q, lo_q[XLEN-1]};
    div_ge   = div_tmp >= {1'b0, opb_q};
    div_sub  = div_tmp[XLEN-1:0] - opb_q;
    div_hi   = div_ge ? div_sub : div_tmp[XLEN-1:0];
    div_lo   = {lo_q[XLEN-2:0], div_ge};
    prod     = {mul_hi, mul_lo};
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -div_lo : div_lo;
    rem_fix  = a_neg_q ? -div_hi : div_hi;
    case (f3_q)
      3'd0:       final_res = prod_fix[XLEN-1:0];
      3'd4, 3'd5: final_res = quo_fix;
      3'd6, 3'd7: final_res = rem_fix;
      default:    final_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // Sign flags are only raised for signed operands, so unsigned ops skip every fix-up.
  always_comb begin
    signed_a  = (bus.funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    signed_b  = (bus.funct3_i inside {3'd0, 3'd1, 3'd4, 3'd6});
    is_div_in = bus.funct3_i[2];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    f3_d     = f3_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          a_neg_d = signed_a & bus.a_i[XLEN-1];
          b_neg_d = signed_b & bus.b_i[XLEN-1];
          f3_d    = bus.funct3_i;
          hi_d    = '0;
          lo_d    = a_neg_d ? -bus.a_i : bus.a_i;
          opb_d   = b_neg_d ? -bus.b_i : bus.b_i;
          cnt_d   = '0;
          if (is_div_in && bus.b_i == '0) begin
            result_d = bus.funct3_i[1] ? bus.a_i : ONES;
            state_d  = DONE;
          end else if (is_div_in && !bus.funct3_i[0] && bus.a_i == MIN_NEG && bus.b_i == ONES) begin
            result_d = bus.funct3_i[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        hi_d  = f3_q[2] ? div_hi : mul_hi;
        lo_d  = f3_q[2] ? div_lo : mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush abandons whatever is in flight and leaves the last result visible.
    if (bus.flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      f3_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      f3_q     <= f3_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
    end
  end

  assign bus.busy_o   = (state_q == RUN);
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = result_q;
  assign bus.stall_o  = bus.start_i & ~bus.done_o & ~bus.flush_i;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: 64-bit products of sign/zero-extended operands and native SV division.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint xa, xb;
    logic [63:0] p;
    int sa, sb;
    xa = (f == 3'd3) ? longint'({32'd0, a}) : longint'($signed(a));
    xb = (f <= 3'd1) ? longint'($signed(b)) : longint'({32'd0, b});
    p  = 64'(xa * xb);
    sa = $signed(a);
    sb = $signed(b);
    if (f == 3'd0) return p[31:0];
    if (f <= 3'd3) return p[63:32];
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      3'd4:    return 32'(sa / sb);
      3'd5:    return a / b;
      3'd6:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Drives one op (start held high) and reports result, latency and stall_o misbehaviour.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stall_err);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = f;
    bus.a_i      = a;
    bus.b_i      = b;
    lat = -1;
    res = 32'hxxxx_xxxx;
    stall_err = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus.done_o === 1'b1) begin
        if (bus.stall_o !== 1'b0) stall_err++;
        lat = c;
        res = bus.result_o;
        break;
      end
      if (bus.stall_o !== 1'b1) stall_err++;
      if (c < 99) @(negedge clk);
    end
    $display("op f3=%0d a=%08h b=%08h result=%08h latency=%0d", f, a, b, res, lat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.funct3_i = 3'd0; bus.a_i = '0; bus.b_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    checks++; if (bus.result_o !== 32'd0) begin failures++; $display("FAIL reset_result got=%08h exp=0", bus.result_o); end
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul_basic;
    logic [31:0] r; int lat, se;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, lat, se);
    bus.start_i = 1'b0;
    checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_7x-3 got=%08h exp=ffffffeb", r); end
    checks++; if (lat != 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++; if (se != 0) begin failures++; $display("FAIL mul_stall errors=%0d exp=0", se); end
  endtask

  task automatic test_mul_high;
    logic [2:0]  fs[3]  = '{3'd1, 3'd2, 3'd3};
    logic [31:0] exp[3] = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
    logic [31:0] r; int lat, se;
    for (int i = 0; i < 3; i++) begin
      run_op(fs[i], 32'h8000_0000, 32'h8000_0000, r, lat, se);
      bus.start_i = 1'b0;
      checks++; if (r !== exp[i]) begin failures++; $display("FAIL mulh_f3=%0d got=%08h exp=%08h", fs[i], r, exp[i]); end
    end
  endtask

  task automatic test_div_basic;
    logic [2:0]  fs[3]  = '{3'd4, 3'd6, 3'd5};
    logic [31:0] as[3]  = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFFF};
    logic [31:0] bs[3]  = '{32'd6, 32'd6, 32'd2};
    logic [31:0] exp[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    logic [31:0] r; int lat, se;
    for (int i = 0; i < 3; i++) begin
      run_op(fs[i], as[i], bs[i], r, lat, se);
      bus.start_i = 1'b0;
      checks++; if (r !== exp[i]) begin failures++; $display("FAIL div_f3=%0d got=%08h exp=%08h", fs[i], r, exp[i]); end
      checks++; if (lat != 33) begin failures++; $display("FAIL div_latency_f3=%0d got=%0d exp=33", fs[i], lat); end
    end
  endtask

  task automatic test_special;
    logic [2:0]  fs[4]  = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] r; int lat, se;
    for (int i = 0; i < 4; i++) begin
      run_op(fs[i], as[i], bs[i], r, lat, se);
      bus.start_i = 1'b0;
      checks++; if (r !== exp[i]) begin failures++; $display("FAIL special_%0d got=%08h exp=%08h", i, r, exp[i]); end
      checks++; if (lat != 1) begin failures++; $display("FAIL special_latency_%0d got=%0d exp=1", i, lat); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] prev, r; int lat, se, seen;
    prev = bus.result_o;
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = 3'd4; bus.a_i = 32'd100; bus.b_i = 32'd7;
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall_o); end
    @(negedge clk);
    bus.flush_i = 1'b0; bus.start_i = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy_o); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done_o === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_done_pulses got=%0d exp=0", seen); end
    checks++; if (bus.result_o !== prev) begin failures++; $display("FAIL flush_result got=%08h exp=%08h", bus.result_o, prev); end
    run_op(3'd0, 32'd3, 32'd4, r, lat, se);
    bus.start_i = 1'b0;
    checks++; if (r !== 32'd12) begin failures++; $display("FAIL after_flush_mul got=%08h exp=0000000c", r); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = 3'd0; bus.a_i = 32'd5; bus.b_i = 32'd6;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", bus.busy_o); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL async_reset_done got=%b exp=0", bus.done_o); end
    checks++; if (bus.result_o !== 32'd0) begin failures++; $display("FAIL async_reset_result got=%08h exp=0", bus.result_o); end
    @(negedge clk);
    bus.start_i = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2; int l1, l2, se; longint t1, t2;
    run_op(3'd0, 32'd1234, 32'd5678, r1, l1, se);
    t1 = cyc;
    run_op(3'd5, 32'd1000, 32'd7, r2, l2, se);
    t2 = cyc;
    bus.start_i = 1'b0;
    checks++; if (r1 !== 32'd7006652) begin failures++; $display("FAIL b2b_mul got=%08h exp=%08h", r1, 32'd7006652); end
    checks++; if (r2 !== 32'd142) begin failures++; $display("FAIL b2b_divu got=%08h exp=%08h", r2, 32'd142); end
    checks++; if (t2 - t1 != 34) begin failures++; $display("FAIL b2b_spacing got=%0d exp=34", t2 - t1); end
  endtask

  task automatic test_random;
    logic [2:0] f; logic [31:0] a, b, r, e; int lat, se, el;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      e  = model(f, a, b);
      el = lat_model(f, a, b);
      run_op(f, a, b, r, lat, se);
      bus.start_i = 1'b0;
      checks++; if (r !== e || lat != el || se != 0)
        begin failures++; $display("FAIL random_%0d f3=%0d a=%08h b=%08h got=%08h/%0d/%0d exp=%08h/%0d/0", i, f, a, b, r, lat, se, e, el); end
    end
  endtask

  initial begin
    test_reset;
    test_mul_basic;
    test_mul_high;
    test_div_basic;
    test_special;
    test_flush;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
